// File: rtl/uart_rx_if.sv
// Byte handshake between the UART receiver and its consumer.
// The receiver drives the data and valid signals. The consumer returns the ack.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, samples each bit at mid-bit and stores the byte
// in a one-deep register with a valid/ack handshake. It also flags framing errors and overruns.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [15:0] i_clock_div,
  input  logic        i_rx,
  uart_rx_if.master   io_rx,
  output logic        o_rx_busy,
  output logic        o_rx_frame_err,
  output logic        o_rx_overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx_s;

  logic [15:0] r_cnt;
  logic [15:0] r_div;
  logic [15:0] r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_busy;
  logic        r_frame_err;
  logic        r_overrun;

  logic w_half_done;
  logic w_bit_done;
  logic w_last_bit;
  logic w_latch_div;
  logic w_cnt_clr;
  logic w_bit_clr;
  logic w_shift;
  logic w_store;
  logic w_frame_err;

  assign w_rx_s      = r_sync[SYNC_STAGES-1];
  assign w_half_done = (r_cnt == ((r_div >> 1) - 16'd1));
  assign w_bit_done  = (r_cnt == (r_div - 16'd1));
  assign w_last_bit  = (r_bit_idx == 16'd7);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_rx_s) w_next = S_START;
      S_START: if (w_half_done) w_next = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_bit_done && w_last_bit) w_next = S_STOP;
      S_STOP:  if (w_bit_done) w_next = w_rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (w_rx_s) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Sample strobes: the counter restarts at every state change and after every bit sample.
  always_comb begin
    w_latch_div = 1'b0;
    w_cnt_clr   = 1'b0;
    w_bit_clr   = 1'b0;
    w_shift     = 1'b0;
    w_store     = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_clr   = 1'b1;
        w_latch_div = !w_rx_s;
      end
      S_START: begin
        w_cnt_clr = w_half_done;
        w_bit_clr = w_half_done;
      end
      S_DATA: begin
        w_cnt_clr = w_bit_done;
        w_shift   = w_bit_done;
      end
      S_STOP: begin
        w_cnt_clr   = w_bit_done;
        w_store     = w_bit_done && w_rx_s;
        w_frame_err = w_bit_done && !w_rx_s;
      end
      S_BREAK: w_cnt_clr = 1'b1;
      default: w_cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_sync      <= '1;
      r_cnt       <= '0;
      r_div       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_cnt       <= w_cnt_clr ? 16'd0 : r_cnt + 16'd1;
      r_busy      <= (w_next != S_IDLE);
      r_frame_err <= w_frame_err;
      // An ack in the store cycle consumes the old byte, so overwriting it is no overrun.
      r_overrun   <= w_store && r_rx_valid && !io_rx.rx_ack;
      if (w_latch_div) begin
        r_div <= i_clock_div;
      end
      if (w_bit_clr) begin
        r_bit_idx <= 16'd0;
      end else if (w_shift) begin
        r_bit_idx <= r_bit_idx + 16'd1;
      end
      if (w_shift) begin
        r_shift <= {w_rx_s, r_shift[7:1]};
      end
      if (w_store) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (io_rx.rx_ack && r_rx_valid) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign io_rx.rx_data  = r_rx_data;
  assign io_rx.rx_valid = r_rx_valid;
  assign o_rx_busy      = r_busy;
  assign o_rx_frame_err = r_frame_err;
  assign o_rx_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: bit-bangs 8N1 frames onto rx. Each received byte and its arrival cycle
// are checked against a frame-level model of the receiver.
module tb_uart_rx;

  localparam int SYNC = 2;
  localparam int DIV  = 217;

  logic        clock    = 1'b0;
  logic        reset    = 1'b0;
  logic [15:0] clockDiv = 16'(DIV);
  logic        rx       = 1'b1;
  logic        busy;
  logic        frameErr;
  logic        overrun;

  uart_rx_if rxIf();

  int errors    = 0;
  int checks    = 0;
  int cycle     = 0;
  int ferrCount = 0;
  int ovrCount  = 0;
  int ferrWide  = 0;
  int ovrWide   = 0;
  logic prevFerr = 1'b0;
  logic prevOvr  = 1'b0;
  logic [7:0] expQ[$];

  uart_rx #(.SYNC_STAGES(SYNC)) dut (
    .i_clock        (clock),
    .i_reset        (reset),
    .i_clock_div    (clockDiv),
    .i_rx           (rx),
    .io_rx          (rxIf),
    .o_rx_busy      (busy),
    .o_rx_frame_err (frameErr),
    .o_rx_overrun   (overrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle++;

  // Pulse accounting: counts each error pulse and any pulse lasting more than one cycle.
  always @(negedge clock) begin
    if (frameErr === 1'b1) ferrCount++;
    if (overrun === 1'b1) ovrCount++;
    if (frameErr === 1'b1 && prevFerr === 1'b1) ferrWide++;
    if (overrun === 1'b1 && prevOvr === 1'b1) ovrWide++;
    prevFerr = frameErr;
    prevOvr  = overrun;
  end

  // Model arrival time. The mid-start search takes div/2 cycles and eight data bits plus a stop bit take 9*div.
  // The synchroniser and the IDLE cycle that registers the start edge add SYNC+1 cycles on top of that.
  function automatic int modelLatency(input int div);
    return div / 2 + 9 * div + SYNC + 1;
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic alignEdge();
    @(posedge clock);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stopBit);
    rx = 1'b0;
    waitCycles(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      waitCycles(DIV);
    end
    rx = stopBit;
    waitCycles(DIV);
  endtask

  task automatic waitValidRise(input int start, output int lat, output bit ok);
    int n;
    ok  = 1'b0;
    lat = -1;
    n   = 0;
    while (!ok && n < 12 * DIV) begin
      @(negedge clock);
      n++;
      if (rxIf.rx_valid === 1'b1) begin
        ok  = 1'b1;
        lat = cycle - start;
      end
    end
  endtask

  task automatic txAndWait(input logic [7:0] b, output logic [7:0] data, output int lat,
                           output bit ok);
    int start;
    alignEdge();
    start = cycle;
    expQ.push_back(b);
    fork
      sendFrame(b, 1'b1);
      waitValidRise(start, lat, ok);
    join
    data = rxIf.rx_data;
  endtask

  task automatic pulseAck();
    alignEdge();
    rxIf.rx_ack = 1'b1;
    waitCycles(1);
    rxIf.rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rx = 1'($urandom_range(0, 1));
      waitCycles(1);
    end
    @(negedge clock);
    checks++;
    if (rxIf.rx_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected 00", rxIf.rx_data);
    end
    checks++;
    if (rxIf.rx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid_busy: got %b/%b expected 0/0", rxIf.rx_valid, busy);
    end
    checks++;
    if (frameErr !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b/%b expected 0/0", frameErr, overrun);
    end
    alignEdge();
    rx    = 1'b1;
    reset = 1'b1;
    waitCycles(50);
    @(negedge clock);
    checks++;
    if (rxIf.rx_valid !== 1'b0 || busy !== 1'b0 || ferrCount != 0 || ovrCount != 0) begin
      errors++;
      $display("[TB] FAIL idle_quiet: got valid=%b busy=%b ferr=%0d ovr=%0d expected all 0",
               rxIf.rx_valid, busy, ferrCount, ovrCount);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] bytes[8];
    logic [7:0] data;
    logic [7:0] exp;
    int lat;
    bit ok;
    bytes[0] = 8'h41;
    bytes[1] = 8'h44;
    bytes[2] = 8'h41;
    bytes[3] = 8'h4D;
    for (int i = 4; i < 8; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      txAndWait(bytes[i], data, lat, ok);
      exp = expQ.pop_front();
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL loopback_timeout: byte %0d got no rx_valid, expected one", i);
      end
      checks++;
      if (data !== exp) begin
        errors++;
        $display("[TB] FAIL loopback_data: byte %0d got %h expected %h", i, data, exp);
      end
      checks++;
      if (lat < modelLatency(DIV) - SYNC - 1 || lat > modelLatency(DIV)) begin
        errors++;
        $display("[TB] FAIL loopback_latency: byte %0d got %0d expected %0d..%0d", i, lat,
                 modelLatency(DIV) - SYNC - 1, modelLatency(DIV));
      end
      pulseAck();
      @(negedge clock);
      checks++;
      if (rxIf.rx_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ack_clear: byte %0d got valid=%b expected 0", i, rxIf.rx_valid);
      end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] data;
    int lat;
    int f0;
    bit ok;
    bit busySeen;
    bit validSeen;
    f0        = ferrCount;
    busySeen  = 1'b0;
    validSeen = 1'b0;
    alignEdge();
    rx = 1'b0;
    for (int i = 0; i < 50; i++) begin
      waitCycles(1);
      if (busy === 1'b1) busySeen = 1'b1;
    end
    rx = 1'b1;
    for (int i = 0; i < 400; i++) begin
      waitCycles(1);
      if (busy === 1'b1) busySeen = 1'b1;
      if (rxIf.rx_valid !== 1'b0) validSeen = 1'b1;
    end
    @(negedge clock);
    checks++;
    if (!busySeen || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL glitch_busy: got seen=%b final=%b expected 1/0", busySeen, busy);
    end
    checks++;
    if (validSeen || ferrCount != f0) begin
      errors++;
      $display("[TB] FAIL glitch_quiet: got valid=%b ferr=%0d expected 0/0", validSeen,
               ferrCount - f0);
    end
    txAndWait(8'h55, data, lat, ok);
    checks++;
    if (!ok || data !== expQ.pop_front()) begin
      errors++;
      $display("[TB] FAIL glitch_next: got ok=%b data=%h expected 1/55", ok, data);
    end
    pulseAck();
  endtask

  task automatic test_break();
    logic [7:0] data;
    int lat;
    int f0;
    bit ok;
    f0 = ferrCount;
    alignEdge();
    sendFrame(8'hA5, 1'b0);
    waitCycles(3000);
    @(negedge clock);
    checks++;
    if (ferrCount - f0 != 1) begin
      errors++;
      $display("[TB] FAIL break_ferr_count: got %0d expected 1", ferrCount - f0);
    end
    checks++;
    if (rxIf.rx_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL break_hold: got valid=%b busy=%b expected 0/1", rxIf.rx_valid, busy);
    end
    alignEdge();
    rx = 1'b1;
    waitCycles(SYNC + 3);
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL break_exit: got busy=%b expected 0", busy);
    end
    txAndWait(8'h3C, data, lat, ok);
    checks++;
    if (!ok || data !== expQ.pop_front()) begin
      errors++;
      $display("[TB] FAIL break_next: got ok=%b data=%h expected 1/3c", ok, data);
    end
    pulseAck();
  endtask

  task automatic test_overrun();
    logic [7:0] data;
    int lat;
    int o0;
    bit ok;
    o0 = ovrCount;
    txAndWait(8'h12, data, lat, ok);
    void'(expQ.pop_front());
    alignEdge();
    sendFrame(8'h34, 1'b1);
    @(negedge clock);
    checks++;
    if (ovrCount - o0 != 1) begin
      errors++;
      $display("[TB] FAIL overrun_pulse: got %0d expected 1", ovrCount - o0);
    end
    checks++;
    if (rxIf.rx_valid !== 1'b1 || rxIf.rx_data !== 8'h34) begin
      errors++;
      $display("[TB] FAIL overrun_data: got valid=%b data=%h expected 1/34", rxIf.rx_valid,
               rxIf.rx_data);
    end
    pulseAck();
    o0 = ovrCount;
    txAndWait(8'h12, data, lat, ok);
    void'(expQ.pop_front());
    alignEdge();
    fork
      sendFrame(8'h34, 1'b1);
      begin
        waitCycles(modelLatency(DIV) - 1);
        rxIf.rx_ack = 1'b1;
        waitCycles(1);
        rxIf.rx_ack = 1'b0;
      end
    join
    @(negedge clock);
    checks++;
    if (ovrCount != o0) begin
      errors++;
      $display("[TB] FAIL ack_store_no_overrun: got %0d pulses expected 0", ovrCount - o0);
    end
    checks++;
    if (rxIf.rx_valid !== 1'b1 || rxIf.rx_data !== 8'h34) begin
      errors++;
      $display("[TB] FAIL ack_store_keep: got valid=%b data=%h expected 1/34", rxIf.rx_valid,
               rxIf.rx_data);
    end
    pulseAck();
  endtask

  task automatic test_reset_mid();
    logic [7:0] data;
    logic [7:0] first;
    int lat;
    bit ok;
    first = 8'($urandom);
    txAndWait(first, data, lat, ok);
    void'(expQ.pop_front());
    alignEdge();
    fork
      sendFrame(8'hFF, 1'b1);
      begin
        waitCycles(SYNC + 1 + DIV / 2 + 3 * DIV);
        @(negedge clock);
        checks++;
        if (busy !== 1'b1 || rxIf.rx_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL mid_before: got busy=%b valid=%b expected 1/1", busy,
                   rxIf.rx_valid);
        end
        alignEdge();
        reset = 1'b0;
        waitCycles(1);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || rxIf.rx_valid !== 1'b0 || rxIf.rx_data !== 8'h00) begin
          errors++;
          $display("[TB] FAIL mid_reset: got busy=%b valid=%b data=%h expected 0/0/00", busy,
                   rxIf.rx_valid, rxIf.rx_data);
        end
      end
    join
    txAndWait(8'h0F, data, lat, ok);
    checks++;
    if (!ok || data !== expQ.pop_front()) begin
      errors++;
      $display("[TB] FAIL mid_next: got ok=%b data=%h expected 1/0f", ok, data);
    end
    pulseAck();
  endtask

  task automatic test_pulse_width();
    checks++;
    if (ferrWide != 0 || ovrWide != 0) begin
      errors++;
      $display("[TB] FAIL pulse_width: got wide ferr=%0d ovr=%0d expected 0/0", ferrWide,
               ovrWide);
    end
  endtask

  initial begin
    rxIf.rx_ack = 1'b0;
    test_reset();
    test_loopback();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_mid();
    test_pulse_width();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
